// File: rtl/key_step_if.sv
// rtl/key_step_if.sv - button/run inputs and step outputs of the step-clock source
interface key_step_if #(
  parameter int CNT_W = 16
);
  logic             key_n;
  logic             run_en;
  logic             step;
  logic             pressed;
  logic [CNT_W-1:0] step_count;

  modport master (
    output key_n,
    output run_en,
    input  step,
    input  pressed,
    input  step_count
  );

  modport slave (
    input  key_n,
    input  run_en,
    output step,
    output pressed,
    output step_count
  );
endinterface

// File: rtl/key_step_ctrl.sv
// rtl/key_step_ctrl.sv - debounced push-button / auto-run step pulse generator
module key_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int RUN_PERIOD      = 25_000_000,
  parameter int CNT_W           = 16
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  key_step_if.slave  bus
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PER_W = $clog2(RUN_PERIOD + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t           state;
  logic [DB_W-1:0]  db_cnt;
  logic [PER_W-1:0] per_cnt;
  logic             key_s1, key_s2;
  logic             run_s1, run_s2;
  logic             key;
  logic             db_done;
  logic             btn_fire;
  logic             run_fire;
  logic             step_next;

  assign key = ~key_s2;

  always_comb begin
    db_done   = (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    btn_fire  = (state == PRESS_WAIT) && key && db_done;
    run_fire  = run_s2 && (per_cnt == PER_W'(RUN_PERIOD - 1));
    // Run mode owns the step output; the button FSM keeps tracking but is muted.
    step_next = run_s2 ? run_fire : btn_fire;
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      key_s1         <= 1'b1;
      key_s2         <= 1'b1;
      run_s1         <= 1'b0;
      run_s2         <= 1'b0;
      state          <= IDLE;
      db_cnt         <= '0;
      per_cnt        <= '0;
      bus.step       <= 1'b0;
      bus.pressed    <= 1'b0;
      bus.step_count <= '0;
    end else begin
      key_s1 <= bus.key_n;
      key_s2 <= key_s1;
      run_s1 <= bus.run_en;
      run_s2 <= run_s1;

      bus.step <= step_next;
      if (step_next) bus.step_count <= bus.step_count + CNT_W'(1);

      if (!run_s2 || run_fire) per_cnt <= '0;
      else                     per_cnt <= per_cnt + PER_W'(1);

      case (state)
        IDLE: begin
          db_cnt <= '0;
          if (key) state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!key) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_done) begin
            state       <= HELD;
            db_cnt      <= '0;
            bus.pressed <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        HELD: begin
          db_cnt <= '0;
          if (!key) state <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (key) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (db_done) begin
            state       <= IDLE;
            db_cnt      <= '0;
            bus.pressed <= 1'b0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_step_ctrl.sv
// tb/tb_key_step_ctrl.sv - self-checking bench for key_step_ctrl
module tb_key_step_ctrl;
  localparam int D  = 4;
  localparam int RP = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_step_if #(.CNT_W(CW)) bus ();

  key_step_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .RUN_PERIOD(RP),
    .CNT_W(CW)
  ) dut (
    .CLOCK_50(clk),
    .Reset(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  bit chk_en = 1'b0;

  // Model state: debounced level, streak of samples disagreeing with it,
  // length of the current synchronized run-enable stretch, and total steps.
  logic kq[$];
  logic rq[$];
  logic m_step = 1'b0;
  logic m_pressed = 1'b0;
  int   m_streak = 0;
  int   m_run_len = 0;
  int   m_count = 0;
  logic m_key, m_run, m_bfire;
  int   step_log[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_no, act, exp);
    end
  endtask

  always @(posedge clk) begin
    edge_no++;
    if (rst) begin
      kq = '{1'b1, 1'b1};
      rq = '{1'b0, 1'b0};
      m_step = 1'b0;
      m_pressed = 1'b0;
      m_streak = 0;
      m_run_len = 0;
      m_count = 0;
    end else begin
      m_key = !kq[0];
      m_run = rq[0];
      void'(kq.pop_front());
      kq.push_back(bus.key_n);
      void'(rq.pop_front());
      rq.push_back(bus.run_en);
      m_bfire = 1'b0;
      // A level change is accepted once D+1 consecutive samples disagree.
      if (m_key != m_pressed) m_streak++;
      else m_streak = 0;
      if (m_streak == D + 1) begin
        m_pressed = m_key;
        m_streak = 0;
        m_bfire = m_key;
      end
      m_run_len = m_run ? m_run_len + 1 : 0;
      m_step = m_run ? (m_run_len % RP == 0) : m_bfire;
      if (m_step) m_count = (m_count + 1) % (1 << CW);
    end
  end

  always @(posedge clk) begin
    #1;
    if (bus.step && !rst) step_log.push_back(edge_no);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("step", int'(bus.step), int'(m_step));
      check("pressed", int'(bus.pressed), int'(m_pressed));
      check("step_count", int'(bus.step_count), m_count);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input logic v, output int base);
    @(negedge clk);
    bus.key_n = v;
    base = edge_no + 1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  int base, rbase, fall;
  bit seen;

  initial begin
    bus.key_n = 1'b1;
    bus.run_en = 1'b0;
    cycles(3);
    check("reset_step", int'(bus.step), 0);
    check("reset_pressed", int'(bus.pressed), 0);
    check("reset_count", int'(bus.step_count), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    cycles(4);

    // 1: clean press, step exactly six edges after first low sample
    step_log.delete();
    set_key(1'b0, base);
    cycles(20);
    check("t1_nsteps", step_log.size(), 1);
    if (step_log.size() > 0) check("t1_latency", step_log[0] - base, 6);
    check("t1_count", int'(bus.step_count), 1);
    check("t1_pressed", int'(bus.pressed), 1);
    set_key(1'b1, rbase);
    seen = 1'b0;
    fall = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!bus.pressed) begin
        seen = 1'b1;
        fall = edge_no;
      end
    end
    check("t1_release_seen", int'(seen), 1);
    check("t1_release_latency", fall - rbase, 6);
    cycles(8);

    // 2: bouncy press, step only after a stable stretch
    step_log.delete();
    set_key(1'b0, base);
    cycles(2);
    set_key(1'b1, base);
    set_key(1'b0, base);
    cycles(1);
    set_key(1'b1, base);
    set_key(1'b0, base);
    cycles(20);
    check("t2_nsteps", step_log.size(), 1);
    if (step_log.size() > 0) check("t2_latency", step_log[0] - base, 6);
    check("t2_count", int'(bus.step_count), 2);
    set_key(1'b1, rbase);
    cycles(12);

    // 3: auto-run, button muted, stops when run drops
    step_log.delete();
    @(negedge clk);
    bus.run_en = 1'b1;
    base = edge_no + 1;
    cycles(11);
    set_key(1'b0, rbase);
    cycles(11);
    set_key(1'b1, rbase);
    cycles(11);
    @(negedge clk);
    bus.run_en = 1'b0;
    cycles(20);
    check("t3_nsteps", step_log.size(), 4);
    for (int i = 0; i < step_log.size() && i < 4; i++)
      check("t3_period", step_log[i] - base, 9 + RP * i);
    check("t3_count", int'(bus.step_count), 6);

    // 4: counter wrap over 16 presses
    pulse_reset();
    cycles(3);
    for (int i = 1; i <= 16; i++) begin
      set_key(1'b0, base);
      cycles(9);
      set_key(1'b1, base);
      cycles(9);
      check("t4_count", int'(bus.step_count), i % 16);
    end

    // 5: reset mid-press discards progress, then a fresh press is seen
    set_key(1'b0, base);
    cycles(4);
    step_log.delete();
    rst = 1'b1;
    cycles(2);
    check("t5_rst_step", int'(bus.step), 0);
    check("t5_rst_count", int'(bus.step_count), 0);
    check("t5_rst_pressed", int'(bus.pressed), 0);
    rst = 1'b0;
    base = edge_no + 1;
    cycles(15);
    check("t5_nsteps", step_log.size(), 1);
    if (step_log.size() > 0) check("t5_latency", step_log[0] - base, 6);
    check("t5_count", int'(bus.step_count), 1);
    set_key(1'b1, base);
    cycles(12);

    // 6: long hold never repeats
    step_log.delete();
    set_key(1'b0, base);
    cycles(100);
    check("t6_nsteps", step_log.size(), 1);
    check("t6_pressed", int'(bus.pressed), 1);
    check("t6_count", int'(bus.step_count), 2);
    set_key(1'b1, base);
    cycles(12);
    check("t6_released", int'(bus.pressed), 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
